// File: rtl/sdram_cpu_bridge.sv
// 16-bit CPU/ROM bus to 64-bit single-beat SDRAM controller bridge with a one-line read cache.
// Optional hit/miss counters are built when SDRAM_BRIDGE_STATS_EN is defined.
module sdram_cpu_bridge #(
    parameter int         CACHE_EN = 1,
    parameter logic [7:0] BURST    = 8'd1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [23:0] cpu_addr,
    input  logic        cpu_rd,
    input  logic        cpu_wr,
    input  logic [1:0]  cpu_ds,
    input  logic [15:0] cpu_din,
    output logic [15:0] cpu_dout,
    output logic        cpu_ack,
    output logic [24:0] mem_addr,
    output logic [63:0] mem_wdata,
    output logic        mem_read,
    output logic        mem_write,
    output logic [7:0]  mem_burstcnt,
    output logic [7:0]  mem_byteenable,
    input  logic        mem_busy,
    input  logic [63:0] mem_rdata,
    input  logic        mem_rdata_ready
`ifdef SDRAM_BRIDGE_STATS_EN
    ,
    output logic [15:0] stat_hits,
    output logic [15:0] stat_misses
`endif
);

    typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_DONE, ACK} state_t;

    state_t      state;
    logic        busy_seen;
    logic        req_live;
    logic        line_valid;
    logic [63:0] line;
    logic [21:0] line_tag;
    logic [1:0]  req_lane;

    logic [1:0]  cpu_lane;
    logic [21:0] cpu_tag;
    logic [21:0] req_tag;
    logic        cpu_hit;
    logic        accept;
    logic        fill;

    function automatic logic [15:0] select_word(input logic [63:0] data, input logic [1:0] lane);
        logic [15:0] w;
        case (lane)
            2'd0:    w = data[15:0];
            2'd1:    w = data[31:16];
            2'd2:    w = data[47:32];
            default: w = data[63:48];
        endcase
        return w;
    endfunction

    function automatic logic [7:0] lane_enables(input logic [1:0] ds, input logic [1:0] lane);
        logic [7:0] be;
        be = {6'b0, ds} << {lane, 1'b0};
        return be;
    endfunction

    function automatic logic [63:0] merge_line(input logic [63:0] cur, input logic [63:0] wdata,
                                               input logic [7:0] be);
        logic [63:0] m;
        m = cur;
        for (int i = 0; i < 8; i++)
            if (be[i]) m[8*i +: 8] = wdata[8*i +: 8];
        return m;
    endfunction

`ifdef SDRAM_BRIDGE_STATS_EN
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction
`endif

    assign cpu_lane     = cpu_addr[1:0];
    assign cpu_tag      = cpu_addr[23:2];
    assign req_tag      = mem_addr[24:3];
    assign cpu_hit      = line_valid && (line_tag == cpu_tag);
    assign mem_burstcnt = BURST;

    // The controller raises busy when it picks up our request; its fall marks acceptance.
    assign accept = busy_seen && !mem_busy;
    assign fill   = mem_rdata_ready && ((state == RD_WAIT) || (state == RD_REQ && accept));

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            cpu_ack        <= 1'b0;
            cpu_dout       <= 16'h0;
            mem_read       <= 1'b0;
            mem_write      <= 1'b0;
            mem_addr       <= 25'h0;
            mem_byteenable <= 8'h0;
            line_valid     <= 1'b0;
            busy_seen      <= 1'b0;
            req_live       <= 1'b0;
`ifdef SDRAM_BRIDGE_STATS_EN
            stat_hits      <= 16'h0;
            stat_misses    <= 16'h0;
`endif
        end else begin
            cpu_ack <= 1'b0;
            case (state)
                IDLE: begin
                    busy_seen <= 1'b0;
                    if (cpu_wr) begin
                        mem_addr       <= {cpu_tag, 3'b000};
                        mem_wdata      <= {4{cpu_din}};
                        mem_byteenable <= lane_enables(cpu_ds, cpu_lane);
                        mem_write      <= 1'b1;
                        req_live       <= 1'b1;
                        state          <= WR_REQ;
                    end else if (cpu_rd) begin
                        if (cpu_hit) begin
                            cpu_dout <= select_word(line, cpu_lane);
                            cpu_ack  <= 1'b1;
                            state    <= ACK;
`ifdef SDRAM_BRIDGE_STATS_EN
                            stat_hits <= sat_inc(stat_hits);
`endif
                        end else begin
                            mem_addr       <= {cpu_tag, 3'b000};
                            mem_byteenable <= 8'hFF;
                            req_lane       <= cpu_lane;
                            mem_read       <= 1'b1;
                            req_live       <= 1'b1;
                            state          <= RD_REQ;
                        end
                    end
                end
                RD_REQ: begin
                    if (!cpu_rd) req_live <= 1'b0;
                    if (mem_busy) busy_seen <= 1'b1;
                    if (accept) begin
                        mem_read <= 1'b0;
                        state    <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    if (!cpu_rd) req_live <= 1'b0;
                end
                WR_REQ: begin
                    if (!cpu_wr) req_live <= 1'b0;
                    if (mem_busy) busy_seen <= 1'b1;
                    if (accept) begin
                        mem_write <= 1'b0;
                        state     <= WR_DONE;
                        if (line_valid && line_tag == req_tag)
                            line <= merge_line(line, mem_wdata, mem_byteenable);
                    end
                end
                WR_DONE: begin
                    cpu_ack <= req_live && cpu_wr;
                    state   <= ACK;
                end
                default: begin
                    req_live <= 1'b0;
                    if (!cpu_rd && !cpu_wr) state <= IDLE;
                end
            endcase

            // Fill may land in the same cycle as acceptance; it overrides the RD_WAIT step.
            if (fill) begin
                line       <= mem_rdata;
                line_tag   <= req_tag;
                line_valid <= (CACHE_EN != 0);
                cpu_dout   <= select_word(mem_rdata, req_lane);
                cpu_ack    <= req_live && cpu_rd;
                state      <= ACK;
`ifdef SDRAM_BRIDGE_STATS_EN
                stat_misses <= sat_inc(stat_misses);
`endif
            end
        end
    end

endmodule

// File: tb/tb_sdram_cpu_bridge.sv
// Randomized self-checking bench: a behavioural SDRAM responder plus a word-level memory/cache reference.
module tb_sdram_cpu_bridge;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [23:0] cpu_addr_a [2];
    logic        cpu_rd_a   [2];
    logic        cpu_wr_a   [2];
    logic [1:0]  cpu_ds_a   [2];
    logic [15:0] cpu_din_a  [2];
    logic        mem_busy_a [2] = '{1'b0, 1'b0};
    logic [63:0] mem_rdata_a[2] = '{64'h0, 64'h0};
    logic        mem_rdy_a  [2] = '{1'b0, 1'b0};

    logic [15:0] cpu_dout0, cpu_dout1;
    logic        cpu_ack0, cpu_ack1;
    logic [24:0] mem_addr0, mem_addr1;
    logic [63:0] mem_wdata0, mem_wdata1;
    logic        mem_read0, mem_read1, mem_write0, mem_write1;
    logic [7:0]  mem_burstcnt0, mem_burstcnt1, mem_be0, mem_be1;
`ifdef SDRAM_BRIDGE_STATS_EN
    logic [15:0] stat_hits0, stat_misses0, stat_hits1, stat_misses1;
`endif

    sdram_cpu_bridge #(.CACHE_EN(1), .BURST(8'd1)) u_dut (
        .clk(clk), .reset(reset),
        .cpu_addr(cpu_addr_a[0]), .cpu_rd(cpu_rd_a[0]), .cpu_wr(cpu_wr_a[0]),
        .cpu_ds(cpu_ds_a[0]), .cpu_din(cpu_din_a[0]), .cpu_dout(cpu_dout0), .cpu_ack(cpu_ack0),
        .mem_addr(mem_addr0), .mem_wdata(mem_wdata0), .mem_read(mem_read0), .mem_write(mem_write0),
        .mem_burstcnt(mem_burstcnt0), .mem_byteenable(mem_be0), .mem_busy(mem_busy_a[0]),
        .mem_rdata(mem_rdata_a[0]), .mem_rdata_ready(mem_rdy_a[0])
`ifdef SDRAM_BRIDGE_STATS_EN
        , .stat_hits(stat_hits0), .stat_misses(stat_misses0)
`endif
    );

    sdram_cpu_bridge #(.CACHE_EN(0), .BURST(8'd1)) u_nocache (
        .clk(clk), .reset(reset),
        .cpu_addr(cpu_addr_a[1]), .cpu_rd(cpu_rd_a[1]), .cpu_wr(cpu_wr_a[1]),
        .cpu_ds(cpu_ds_a[1]), .cpu_din(cpu_din_a[1]), .cpu_dout(cpu_dout1), .cpu_ack(cpu_ack1),
        .mem_addr(mem_addr1), .mem_wdata(mem_wdata1), .mem_read(mem_read1), .mem_write(mem_write1),
        .mem_burstcnt(mem_burstcnt1), .mem_byteenable(mem_be1), .mem_busy(mem_busy_a[1]),
        .mem_rdata(mem_rdata_a[1]), .mem_rdata_ready(mem_rdy_a[1])
`ifdef SDRAM_BRIDGE_STATS_EN
        , .stat_hits(stat_hits1), .stat_misses(stat_misses1)
`endif
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [63:0] init_qw(input logic [21:0] idx);
        return {idx, 10'h2A5, idx ^ 22'h155555, 10'h0F3};
    endfunction

    // SDRAM contents as seen by the responder, and the CPU-level reference image.
    logic [63:0] sdram   [logic [21:0]];
    logic [63:0] ref_mem [logic [21:0]];

    function automatic logic [63:0] sd_rd(input logic [21:0] idx);
        if (!sdram.exists(idx)) sdram[idx] = init_qw(idx);
        return sdram[idx];
    endfunction

    function automatic logic [63:0] ref_rd(input logic [21:0] idx);
        if (!ref_mem.exists(idx)) ref_mem[idx] = init_qw(idx);
        return ref_mem[idx];
    endfunction

    logic [24:0] exp_addr;
    logic [63:0] exp_wdata;
    logic [7:0]  exp_be;
    bit          long_data = 1'b0;

    int   ph[2]       = '{0, 0};
    int   cnt[2]      = '{0, 0};
    int   rd_cnt[2]   = '{0, 0};
    int   wr_cnt[2]   = '{0, 0};
    logic prev_req[2] = '{1'b0, 1'b0};
    logic is_rd[2]    = '{1'b0, 1'b0};
    logic [21:0] rq_idx[2];

    logic        r_rd, r_wr;
    logic [24:0] r_a;
    logic [63:0] r_wd, r_q;
    logic [7:0]  r_be, r_bc;
    int          r_dly;

    // Controller model: busy pulse after a request edge, then read data a few cycles later.
    always @(negedge clk) begin
        for (int g = 0; g < 2; g++) begin
            r_rd = (g == 0) ? mem_read0     : mem_read1;
            r_wr = (g == 0) ? mem_write0    : mem_write1;
            r_a  = (g == 0) ? mem_addr0     : mem_addr1;
            r_wd = (g == 0) ? mem_wdata0    : mem_wdata1;
            r_be = (g == 0) ? mem_be0       : mem_be1;
            r_bc = (g == 0) ? mem_burstcnt0 : mem_burstcnt1;
            case (ph[g])
                0: if ((r_rd || r_wr) && !prev_req[g]) begin
                    check_eq("req_excl", {63'h0, r_rd && r_wr}, 64'h0);
                    check_eq("req_addr", {39'h0, r_a}, {39'h0, exp_addr});
                    check_eq("burstcnt", {56'h0, r_bc}, 64'h1);
                    is_rd[g]  = r_rd;
                    rq_idx[g] = r_a[24:3];
                    if (r_rd) rd_cnt[g]++;
                    else begin
                        wr_cnt[g]++;
                        check_eq("wr_wdata", r_wd, exp_wdata);
                        check_eq("wr_be", {56'h0, r_be}, {56'h0, exp_be});
                        r_q = sd_rd(rq_idx[g]);
                        for (int b = 0; b < 8; b++)
                            if (r_be[b]) r_q[8*b +: 8] = r_wd[8*b +: 8];
                        sdram[rq_idx[g]] = r_q;
                    end
                    cnt[g] = $urandom_range(0, 2);
                    ph[g]  = 1;
                end
                1: begin
                    check_eq("req_hold", {63'h0, r_rd || r_wr}, 64'h1);
                    if (cnt[g] == 0) begin
                        mem_busy_a[g] = 1'b1;
                        cnt[g] = $urandom_range(1, 3);
                        ph[g]  = 2;
                    end else cnt[g]--;
                end
                2: begin
                    check_eq("req_hold", {63'h0, r_rd || r_wr}, 64'h1);
                    cnt[g]--;
                    if (cnt[g] == 0) begin
                        mem_busy_a[g] = 1'b0;
                        if (is_rd[g]) begin
                            r_dly = long_data ? 6 : $urandom_range(0, 3);
                            if (r_dly == 0) begin
                                mem_rdy_a[g]   = 1'b1;
                                mem_rdata_a[g] = sd_rd(rq_idx[g]);
                                ph[g] = 4;
                            end else begin
                                cnt[g] = r_dly;
                                ph[g]  = 3;
                            end
                        end else ph[g] = 0;
                    end
                end
                3: begin
                    cnt[g]--;
                    if (cnt[g] == 0) begin
                        mem_rdy_a[g]   = 1'b1;
                        mem_rdata_a[g] = sd_rd(rq_idx[g]);
                        ph[g] = 4;
                    end
                end
                default: begin
                    mem_rdy_a[g] = 1'b0;
                    ph[g] = 0;
                end
            endcase
            prev_req[g] = r_rd || r_wr;
        end
    end

    bit          ref_valid = 1'b0;
    logic [21:0] ref_tag;
    int          exp_hits = 0;
    int          exp_misses = 0;

    task automatic cpu_op(input int inst, input bit wr, input bit rd, input logic [23:0] addr,
                          input logic [1:0] ds, input logic [15:0] din, input bit drop_early,
                          output logic [15:0] dout, output int lat, output bit acked);
        logic [7:0] ds8;
        logic       ack;
        @(negedge clk);
        ds8       = {6'b0, ds};
        exp_addr  = {addr[23:2], 3'b000};
        exp_wdata = {4{din}};
        exp_be    = ds8 << (2 * addr[1:0]);
        cpu_addr_a[inst] = addr;
        cpu_ds_a[inst]   = ds;
        cpu_din_a[inst]  = din;
        cpu_wr_a[inst]   = wr;
        cpu_rd_a[inst]   = rd;
        acked = 1'b0;
        lat   = 0;
        dout  = 16'h0;
        for (int c = 1; c <= 200; c++) begin
            @(posedge clk); #1;
            ack = (inst == 0) ? cpu_ack0 : cpu_ack1;
            if (ack) begin
                acked = 1'b1;
                lat   = c;
                dout  = (inst == 0) ? cpu_dout0 : cpu_dout1;
                break;
            end
            if (drop_early && c == 1) begin
                cpu_rd_a[inst] = 1'b0;
                cpu_wr_a[inst] = 1'b0;
            end
            if (drop_early && c >= 40) break;
        end
        cpu_rd_a[inst] = 1'b0;
        cpu_wr_a[inst] = 1'b0;
        if (!drop_early) check_eq("ack_seen", {63'h0, acked}, 64'h1);
        repeat (3) begin
            @(posedge clk); #1;
            ack = (inst == 0) ? cpu_ack0 : cpu_ack1;
            check_eq("extra_ack", {63'h0, ack}, 64'h0);
        end
    endtask

    task automatic do_read(input logic [23:0] addr);
        logic [21:0] idx;
        logic [63:0] q;
        logic [15:0] dout;
        int          lat, rc;
        bit          acked, hit;
        idx = addr[23:2];
        hit = ref_valid && (ref_tag == idx);
        q   = ref_rd(idx);
        rc  = rd_cnt[0];
        cpu_op(0, 1'b0, 1'b1, addr, 2'b11, 16'h0, 1'b0, dout, lat, acked);
        check_eq("rd_data", {48'h0, dout}, {48'h0, q[16*addr[1:0] +: 16]});
        check_eq("rd_fetch", rd_cnt[0] - rc, hit ? 0 : 1);
        if (hit) begin
            check_eq("hit_lat", lat, 1);
            exp_hits++;
        end else begin
            exp_misses++;
            ref_valid = 1'b1;
            ref_tag   = idx;
        end
    endtask

    task automatic do_write(input logic [23:0] addr, input logic [1:0] ds, input logic [15:0] din,
                            input bit both);
        logic [21:0] idx;
        logic [63:0] q;
        logic [15:0] w, dout;
        int          lat, rc, wc;
        bit          acked;
        idx = addr[23:2];
        rc  = rd_cnt[0];
        wc  = wr_cnt[0];
        cpu_op(0, 1'b1, both, addr, ds, din, 1'b0, dout, lat, acked);
        check_eq("wr_issue", wr_cnt[0] - wc, 1);
        check_eq("wr_noread", rd_cnt[0] - rc, 0);
        q = ref_rd(idx);
        w = q[16*addr[1:0] +: 16];
        if (ds[0]) w[7:0]  = din[7:0];
        if (ds[1]) w[15:8] = din[15:8];
        q[16*addr[1:0] +: 16] = w;
        ref_mem[idx] = q;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] dout;
        logic [23:0] addr;
        int          lat, rc, r;
        bit          acked, saw_ack;

        reset = 1'b1;
        for (int g = 0; g < 2; g++) begin
            cpu_addr_a[g] = 24'h0;
            cpu_rd_a[g]   = 1'b0;
            cpu_wr_a[g]   = 1'b0;
            cpu_ds_a[g]   = 2'b00;
            cpu_din_a[g]  = 16'h0;
        end
        sdram[22'h40]   = 64'h4444_3333_2222_1111;
        ref_mem[22'h40] = 64'h4444_3333_2222_1111;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_ack", {63'h0, cpu_ack0}, 64'h0);
        check_eq("rst_dout", {48'h0, cpu_dout0}, 64'h0);
        check_eq("rst_mem_read", {63'h0, mem_read0}, 64'h0);
        check_eq("rst_mem_write", {63'h0, mem_write0}, 64'h0);
        check_eq("rst_mem_addr", {39'h0, mem_addr0}, 64'h0);
        check_eq("rst_mem_be", {56'h0, mem_be0}, 64'h0);
        reset = 1'b0;

        // Quadword fill then three sequential hits, write-through merge and re-read.
        do_read(24'h000100);
        do_read(24'h000101);
        do_read(24'h000102);
        do_read(24'h000103);
        do_write(24'h000102, 2'b01, 16'hABCD, 1'b0);
        do_read(24'h000102);
        check_eq("merged_word", {48'h0, cpu_dout0}, 64'h33CD);
        do_write(24'h000101, 2'b11, 16'h5A5A, 1'b1);
        do_read(24'h000101);

        // Strobe withdrawn before completion: fill still happens, no ack.
        rc = rd_cnt[0];
        cpu_op(0, 1'b0, 1'b1, 24'h000208, 2'b11, 16'h0, 1'b1, dout, lat, acked);
        check_eq("dropped_ack", {63'h0, acked}, 64'h0);
        check_eq("dropped_fetch", rd_cnt[0] - rc, 1);
        exp_misses++;
        ref_valid = 1'b1;
        ref_tag   = 22'h82;
        do_read(24'h00020A);

        // Reset while waiting for read data; the late data strobe must be ignored.
        long_data = 1'b1;
        @(negedge clk);
        cpu_addr_a[0] = 24'h000300;
        exp_addr      = 25'h000600;
        cpu_rd_a[0]   = 1'b1;
        r = 0;
        for (int c = 0; c < 60; c++) begin
            @(posedge clk); #1;
            if (ph[0] == 3) begin
                r = 1;
                break;
            end
        end
        check_eq("reach_rd_wait", r, 1);
        cpu_rd_a[0] = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check_eq("rst_drop_read", {63'h0, mem_read0}, 64'h0);
        saw_ack = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            if (cpu_ack0) saw_ack = 1'b1;
        end
        check_eq("late_data_ack", {63'h0, saw_ack}, 64'h0);
        long_data  = 1'b0;
        ref_valid  = 1'b0;
        exp_hits   = 0;
        exp_misses = 0;
        do_read(24'h000300);
        do_read(24'h000301);
        do_read(24'h00020A);

        for (int i = 0; i < 150; i++) begin
            addr = 24'h000100 + 24'($urandom_range(0, 11));
            r    = $urandom_range(0, 9);
            if (r < 6) do_read(addr);
            else do_write(addr, 2'($urandom_range(1, 3)), 16'($urandom), r == 9);
        end

        // Cacheless build: every read goes to memory.
        rc = rd_cnt[1];
        cpu_op(1, 1'b0, 1'b1, 24'h000100, 2'b11, 16'h0, 1'b0, dout, lat, acked);
        check_eq("nc_data0", {48'h0, dout}, {48'h0, ref_rd(22'h40) & 64'hFFFF});
        cpu_op(1, 1'b0, 1'b1, 24'h000100, 2'b11, 16'h0, 1'b0, dout, lat, acked);
        check_eq("nc_data1", {48'h0, dout}, {48'h0, ref_rd(22'h40) & 64'hFFFF});
        check_eq("nc_fetches", rd_cnt[1] - rc, 2);

`ifdef SDRAM_BRIDGE_STATS_EN
        check_eq("stat_hits", {48'h0, stat_hits0}, exp_hits);
        check_eq("stat_misses", {48'h0, stat_misses0}, exp_misses);
        check_eq("nc_stat_hits", {48'h0, stat_hits1}, 64'h0);
        check_eq("nc_stat_misses", {48'h0, stat_misses1}, 64'h2);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
